pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised pipeline-stage register. It is the general successor to the fixed per-stage latches between IF/ID/EX/MEM/WB.
- Carries one WIDTH-bit packed stage bundle with valid/ready handshake, global advance qualifier (en, driven by ihit||dhit), synchronous flush, and stall/bubble performance counters.
- SKID=1 adds a 2-entry skid buffer so in_ready is registered, which breaks the ready timing path across stages.

Parameters:
WIDTH, 32, bit width of the stage payload bundle
RESET_VAL, '0, payload value after reset and after flush (WIDTH bits)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready
CNT_W, 16, width of each performance counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
en  in  1  global advance qualifier; no transfer occurs on either side while low
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream has a beat
in_ready  out  1  stage can accept a beat
in_data  in  WIDTH  upstream payload
out_valid  out  1  stage holds a beat for downstream
out_ready  in  1  downstream can accept
out_data  out  WIDTH  payload presented downstream
stall_cnt  out  CNT_W  cycles spent holding a blocked beat
bubble_cnt  out  CNT_W  cycles with no beat to present

Behaviour:
- Reset (RST high, async, any time, including mid-transfer):
  - out_valid=0; out_data=RESET_VAL; skid entry invalid with data RESET_VAL.
  - in_ready=1 for SKID=1. For SKID=0, in_ready follows its combinational equation.
  - stall_cnt=0; bubble_cnt=0.
  - Outputs take these values immediately, not at the next edge.
- Handshake: acc = en & in_valid & in_ready; dep = en & out_valid & out_ready. Latency is 1 cycle from acc to out_valid.
- en low: all state holds, counters hold. Inputs are ignored regardless of valid/ready.
- SKID=0, states EMPTY/FULL:
  - in_ready = !out_valid | out_ready (combinational).
  - acc loads the main register.
  - acc & dep in the same cycle keeps FULL with the new data.
  - dep & !acc goes to EMPTY; out_data holds its last value.
- SKID=1, states EMPTY/ONE/FULL:
  - in_ready = !skid_valid (registered).
  - EMPTY: acc goes to ONE, main<=in_data.
  - ONE: acc&dep stays ONE, main<=in_data. acc&!dep goes to FULL, skid<=in_data. dep&!acc goes to EMPTY.
  - FULL: in_ready=0, so acc is impossible. dep goes to ONE, main<=skid, skid invalid.
  - Order is preserved: out_data is always the oldest beat.
- Flush has priority over everything else except reset, and is not gated by en:
  - Next edge: out_valid=0, skid invalid, out_data=RESET_VAL.
  - A beat presented in the flush cycle is dropped.
  - A dep in the flush cycle still counts as delivered downstream.
  - Counters are not cleared.
- Counters (advance only when en=1, saturate at all-ones, no wrap):
  - stall_cnt +1 when out_valid & !out_ready.
  - bubble_cnt +1 when !out_valid.
  - The flush cycle counts according to the pre-flush state.
- Payload is opaque. No field decoding; widths are exact, with no padding or truncation.

Test Plan:
- Reset, then SKID=1: drive 4 beats 0xA0..0xA3 back-to-back with out_ready=1, en=1 -> out_valid rises 1 cycle after the first accept; out_data sequence A0,A1,A2,A3 with no gaps; in_ready stays 1.
- SKID=1: drop out_ready for 3 cycles mid-stream with in_valid held -> exactly one beat is absorbed into skid, in_ready=0 the following cycle, no loss or duplication; stall_cnt=3.
- Hold en=0 for 5 cycles with in_valid=1 and out_ready=1 -> no state change; out_data and out_valid are frozen; counters are unchanged.
- FULL state with in_valid=1, assert flush for 1 cycle -> next cycle out_valid=0, out_data=RESET_VAL, in_ready=1; the flush-cycle beat is not seen downstream; counters are retained.
- SKID=0, CNT_W=3: keep empty with en=1 for 10 cycles -> bubble_cnt saturates at 7; for a simultaneous acc&dep, in_ready=1 while full and out_ready=1.
- Assert RST asynchronously between edges while FULL -> out_valid=0 and counters=0 before the next CLK edge; normal operation resumes after RST falls.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, global advance qualifier, flush,
// optional 2-entry skid buffer (registered in_ready) and saturating stall/bubble counters.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             r_main_valid, r_skid_valid;
  logic [WIDTH-1:0] r_main_data, r_skid_data;
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

  logic             w_main_valid_nxt, w_skid_valid_nxt;
  logic [WIDTH-1:0] w_main_data_nxt, w_skid_data_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt, w_bubble_cnt_nxt;
  logic             w_in_ready, w_acc, w_dep;

  always_comb begin
    // With a skid buffer, in_ready depends only on flop state, cutting the ready path.
    w_in_ready = SKID ? !r_skid_valid : (!r_main_valid || out_ready);
    w_acc      = en && in_valid && w_in_ready;
    w_dep      = en && r_main_valid && out_ready;

    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;

    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_main_data_nxt  = RESET_VAL;
      w_skid_valid_nxt = 1'b0;
      w_skid_data_nxt  = RESET_VAL;
    end else if (SKID) begin
      if (r_skid_valid) begin
        // FULL: in_ready is low, so only a departure can happen.
        if (w_dep) begin
          w_main_data_nxt  = r_skid_data;
          w_skid_valid_nxt = 1'b0;
        end
      end else if (r_main_valid) begin
        if (w_acc && w_dep) begin
          w_main_data_nxt = in_data;
        end else if (w_acc) begin
          w_skid_valid_nxt = 1'b1;
          w_skid_data_nxt  = in_data;
        end else if (w_dep) begin
          w_main_valid_nxt = 1'b0;
        end
      end else if (w_acc) begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = in_data;
      end
    end else begin
      if (w_acc) begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = in_data;
      end else if (w_dep) begin
        w_main_valid_nxt = 1'b0;
      end
    end

    // Counters see the pre-flush state and saturate at all-ones.
    w_stall_cnt_nxt  = r_stall_cnt;
    w_bubble_cnt_nxt = r_bubble_cnt;
    if (en && r_main_valid && !out_ready && !(&r_stall_cnt)) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
    end
    if (en && !r_main_valid && !(&r_bubble_cnt)) begin
      w_bubble_cnt_nxt = r_bubble_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_main_valid <= 1'b0;
      r_main_data  <= RESET_VAL;
      r_skid_valid <= 1'b0;
      r_skid_data  <= RESET_VAL;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
      r_bubble_cnt <= w_bubble_cnt_nxt;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_main_valid;
  assign out_data   = r_main_data;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a SKID=1 instance and a SKID=0, CNT_W=3 instance.
module tb_pipe_skid_reg;

  logic       CLK = 1'b0;
  logic       RST;
  logic       en, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data, stall_cnt, bubble_cnt;

  logic       en0, flush0, in_valid0, out_ready0;
  logic [7:0] in_data0;
  logic       in_ready0, out_valid0;
  logic [7:0] out_data0;
  logic [2:0] stall_cnt0, bubble_cnt0;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  pipe_skid_reg #(
    .WIDTH(8), .RESET_VAL(8'h5A), .SKID(1'b1), .CNT_W(8)
  ) u_dut1 (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_skid_reg #(
    .WIDTH(8), .RESET_VAL(8'hC3), .SKID(1'b0), .CNT_W(3)
  ) u_dut0 (
    .CLK(CLK), .RST(RST), .en(en0), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    en0 = 1'b0; flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = 8'h00; out_ready0 = 1'b1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    tick();
    checks++; if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b want 0", out_valid); errors++; end
    checks++; if (out_data !== 8'h5A) begin
      $display("FAIL reset_out_data: got %h want 5a", out_data); errors++; end
    checks++; if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", in_ready); errors++; end
    checks++; if (stall_cnt !== 8'd0 || bubble_cnt !== 8'd0) begin
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, bubble_cnt); errors++; end
    checks++; if (out_valid0 !== 1'b0 || out_data0 !== 8'hC3 || in_ready0 !== 1'b1) begin
      $display("FAIL reset_skid0: got v=%b d=%h r=%b want 0 c3 1",
               out_valid0, out_data0, in_ready0); errors++; end
    RST = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      if (i == 0) begin
        checks++; if (out_valid !== 1'b0) begin
          $display("FAIL b2b_latency: got out_valid=%b want 0", out_valid); errors++; end
      end
      checks++; if (in_ready !== 1'b1) begin
        $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); errors++; end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(i)) begin
        $display("FAIL b2b_data[%0d]: got v=%b d=%h want 1 %h", i, out_valid, out_data,
                 8'hA0 + 8'(i)); errors++; end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin
      $display("FAIL b2b_drain: got %b want 0", out_valid); errors++; end
    checks++; if (stall_cnt !== 8'd0 || bubble_cnt !== 8'd1) begin
      $display("FAIL b2b_cnt: got %0d/%0d want 0/1", stall_cnt, bubble_cnt); errors++; end
  endtask

  task automatic test_skid_stall();
    do_reset();
    in_valid = 1'b1; in_data = 8'hB0; out_ready = 1'b1;
    tick();
    in_data = 8'hB1; out_ready = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b0 || out_data !== 8'hB0) begin
      $display("FAIL skid_absorb: got r=%b d=%h want 0 b0", in_ready, out_data); errors++; end
    in_data = 8'hB2;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hB0) begin
      $display("FAIL skid_hold: got r=%b v=%b d=%h want 0 1 b0", in_ready, out_valid,
               out_data); errors++; end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 8'hB1 || in_ready !== 1'b1) begin
      $display("FAIL skid_pop: got d=%h r=%b want b1 1", out_data, in_ready); errors++; end
    tick();
    checks++; if (out_data !== 8'hB2 || out_valid !== 1'b1) begin
      $display("FAIL skid_next: got d=%h v=%b want b2 1", out_data, out_valid); errors++; end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin
      $display("FAIL skid_drain: got %b want 0", out_valid); errors++; end
    checks++; if (stall_cnt !== 8'd3 || bubble_cnt !== 8'd1) begin
      $display("FAIL skid_cnt: got %0d/%0d want 3/1", stall_cnt, bubble_cnt); errors++; end
  endtask

  task automatic test_en_hold();
    do_reset();
    in_valid = 1'b1; in_data = 8'hC0;
    tick();
    en = 1'b0; in_data = 8'hC1;
    for (int i = 0; i < 5; i++) begin
      out_ready = (i < 3);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hC0 || in_ready !== 1'b1 ||
                    stall_cnt !== 8'd0 || bubble_cnt !== 8'd1) begin
        $display("FAIL en_hold[%0d]: got v=%b d=%h r=%b s=%0d b=%0d want 1 c0 1 0 1", i,
                 out_valid, out_data, in_ready, stall_cnt, bubble_cnt); errors++; end
    end
    en = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 8'hC1 || out_valid !== 1'b1 || stall_cnt !== 8'd0) begin
      $display("FAIL en_resume: got d=%h v=%b s=%0d want c1 1 0", out_data, out_valid,
               stall_cnt); errors++; end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = 8'hD0; out_ready = 1'b0;
    tick();
    in_data = 8'hD1;
    tick();
    in_data = 8'hD2; flush = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h5A || in_ready !== 1'b1) begin
      $display("FAIL flush_state: got v=%b d=%h r=%b want 0 5a 1", out_valid, out_data,
               in_ready); errors++; end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin
      $display("FAIL flush_drop: got v=%b d=%h want 0", out_valid, out_data); errors++; end
    checks++; if (stall_cnt !== 8'd2 || bubble_cnt !== 8'd2) begin
      $display("FAIL flush_cnt: got %0d/%0d want 2/2", stall_cnt, bubble_cnt); errors++; end
    in_valid = 1'b1; in_data = 8'hD3;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hD3) begin
      $display("FAIL flush_after: got v=%b d=%h want 1 d3", out_valid, out_data); errors++; end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_data = 8'hE0; out_ready = 1'b0;
    tick();
    in_data = 8'hE1;
    tick();
    in_valid = 1'b0;
    #3;
    RST = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h5A || in_ready !== 1'b1) begin
      $display("FAIL arst_state: got v=%b d=%h r=%b want 0 5a 1", out_valid, out_data,
               in_ready); errors++; end
    checks++; if (stall_cnt !== 8'd0 || bubble_cnt !== 8'd0) begin
      $display("FAIL arst_cnt: got %0d/%0d want 0/0", stall_cnt, bubble_cnt); errors++; end
    #1;
    RST = 1'b0;
    in_valid = 1'b1; in_data = 8'hE2; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hE2 || bubble_cnt !== 8'd1) begin
      $display("FAIL arst_resume: got v=%b d=%h b=%0d want 1 e2 1", out_valid, out_data,
               bubble_cnt); errors++; end
  endtask

  task automatic test_skid0();
    do_reset();
    en = 1'b1; en0 = 1'b1; in_valid0 = 1'b0; out_ready0 = 1'b1;
    checks++; if (in_ready0 !== 1'b1) begin
      $display("FAIL s0_empty_ready: got %b want 1", in_ready0); errors++; end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bubble_cnt0 !== 3'd3) begin
      $display("FAIL s0_bubble3: got %0d want 3", bubble_cnt0); errors++; end
    for (int i = 0; i < 7; i++) tick();
    checks++; if (bubble_cnt0 !== 3'd7) begin
      $display("FAIL s0_bubble_sat: got %0d want 7", bubble_cnt0); errors++; end
    in_valid0 = 1'b1; in_data0 = 8'hF0;
    tick();
    checks++; if (out_valid0 !== 1'b1 || out_data0 !== 8'hF0) begin
      $display("FAIL s0_load: got v=%b d=%h want 1 f0", out_valid0, out_data0); errors++; end
    in_data0 = 8'hF1; out_ready0 = 1'b0;
    #1;
    checks++; if (in_ready0 !== 1'b0) begin
      $display("FAIL s0_full_blocked: got %b want 0", in_ready0); errors++; end
    out_ready0 = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin
      $display("FAIL s0_full_ready: got %b want 1", in_ready0); errors++; end
    tick();
    checks++; if (out_valid0 !== 1'b1 || out_data0 !== 8'hF1) begin
      $display("FAIL s0_acc_dep: got v=%b d=%h want 1 f1", out_valid0, out_data0); errors++; end
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (stall_cnt0 !== 3'd7 || out_data0 !== 8'hF1) begin
      $display("FAIL s0_stall_sat: got s=%0d d=%h want 7 f1", stall_cnt0, out_data0);
      errors++; end
    out_ready0 = 1'b1;
    tick();
    checks++; if (out_valid0 !== 1'b0 || out_data0 !== 8'hF1 || bubble_cnt0 !== 3'd7) begin
      $display("FAIL s0_drain: got v=%b d=%h b=%0d want 0 f1 7", out_valid0, out_data0,
               bubble_cnt0); errors++; end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_skid_stall();
    test_en_hold();
    test_flush();
    test_async_reset();
    test_skid0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
